// File: rtl/alu_pkg.sv
// Shared types for the ALU result path: entry layout, drain states and the
// zero-detect helper used when a result is captured.
package alu_pkg;

    localparam int DATA_W = 32;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              wide;
        logic              zero;
    } z_entry_t;

    typedef enum logic {
        S_LO = 1'b0,
        S_HI = 1'b1
    } drain_state_t;

    // Narrow results compare only the low word; wide ones compare all 64 bits.
    function automatic logic result_is_zero(input logic [DATA_W-1:0] hi,
                                            input logic [DATA_W-1:0] lo,
                                            input logic              wide);
        logic lo_zero;
        logic hi_zero;
        lo_zero = (lo == {DATA_W{1'b0}});
        hi_zero = (hi == {DATA_W{1'b0}});
        if (wide) begin
            return lo_zero && hi_zero;
        end else begin
            return lo_zero;
        end
    endfunction

endpackage

// File: rtl/z_result_stage_if.sv
// ALU-to-bus handshake bundle: result capture side (in_*) and beat drain side (out_*).
interface z_result_stage_if;
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_lo;
    logic [DATA_W-1:0] in_hi;
    logic              in_wide;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_is_hi;
    logic              out_last;
    logic              out_zero;

    modport master (
        output in_valid, in_lo, in_hi, in_wide, out_ready,
        input  in_ready, out_valid, out_data, out_is_hi, out_last, out_zero
    );

    modport slave (
        input  in_valid, in_lo, in_hi, in_wide, out_ready,
        output in_ready, out_valid, out_data, out_is_hi, out_last, out_zero
    );

endinterface

// File: rtl/z_fifo.sv
// Register-array FIFO of result entries with occupancy count and a
// synchronous active-low clear that discards every stored entry.
module z_fifo
    import alu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             push,
    input  z_entry_t         push_data,
    input  logic             pop,
    output z_entry_t         head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    z_entry_t         mem_q [DEPTH];
    z_entry_t         mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Next-state for storage, pointers and occupancy; pointers wrap on power-of-2 depth.
    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == {CNT_W{1'b0}});
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
        head  = mem_q[rd_ptr_q];
        count = count_q;
    end

    // State registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {$bits(z_entry_t){1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/z_result_stage.sv
// Captures ALU results into a small FIFO and drains them onto a 32-bit bus,
// LO beat first and an extra HI beat for wide (mul/div) results.
module z_result_stage
    import alu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             clear_n,
    z_result_stage_if.slave  bus,
    output logic [CNT_W-1:0] count
);

    drain_state_t state_q, state_d;
    z_entry_t     push_entry_s;
    z_entry_t     head_s;
    logic         push_s;
    logic         pop_s;
    logic         hs_s;
    logic         full_s;
    logic         empty_s;

    // Build the entry at capture time; HI is cleared for narrow results.
    always_comb begin
        push_s            = bus.in_valid && !full_s;
        push_entry_s.lo   = bus.in_lo;
        push_entry_s.wide = bus.in_wide;
        if (bus.in_wide) begin
            push_entry_s.hi = bus.in_hi;
        end else begin
            push_entry_s.hi = {DATA_W{1'b0}};
        end
        push_entry_s.zero = result_is_zero(push_entry_s.hi, bus.in_lo, bus.in_wide);
    end

    z_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .clear_n   (clear_n),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count),
        .full      (full_s),
        .empty     (empty_s)
    );

    // in_ready depends only on stored occupancy, never on out_ready.
    assign bus.in_ready  = !full_s;
    assign bus.out_valid = !empty_s;

    // Drain FSM: a wide head stays in the FIFO until its HI beat is taken.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        hs_s    = !empty_s && bus.out_ready;
        case (state_q)
            S_LO: begin
                if (hs_s) begin
                    if (head_s.wide) begin
                        state_d = S_HI;
                    end else begin
                        pop_s = 1'b1;
                    end
                end else begin
                    state_d = S_LO;
                end
            end
            S_HI: begin
                if (hs_s) begin
                    pop_s   = 1'b1;
                    state_d = S_LO;
                end else begin
                    state_d = S_HI;
                end
            end
            default: begin
                state_d = S_LO;
            end
        endcase
    end

    // Beat fields come from the head entry and drain state; all zero while empty.
    always_comb begin
        bus.out_data  = {DATA_W{1'b0}};
        bus.out_is_hi = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_zero  = 1'b0;
        if (!empty_s) begin
            bus.out_zero = head_s.zero;
            case (state_q)
                S_LO: begin
                    bus.out_data = head_s.lo;
                    bus.out_last = !head_s.wide;
                end
                S_HI: begin
                    bus.out_data  = head_s.hi;
                    bus.out_is_hi = 1'b1;
                    bus.out_last  = 1'b1;
                end
                default: begin
                    bus.out_data = {DATA_W{1'b0}};
                end
            endcase
        end else begin
            bus.out_zero = 1'b0;
        end
    end

    // Drain state register.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q <= S_LO;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_z_result_stage.sv
// Directed bench for z_result_stage: hand-computed vectors covering narrow,
// wide, zero detect, backpressure, streaming and mid-transfer reset.
module tb_z_result_stage;

    logic       clock;
    logic       clear_n;
    logic [1:0] count;
    int         tests_run;
    int         tests_failed;

    z_result_stage_if bus_if ();

    z_result_stage #(
        .DEPTH (2)
    ) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus_if),
        .count   (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Advance one rising edge; outputs are then read 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [31:0] hi, input logic [31:0] lo, input logic w);
        bus_if.in_valid = v;
        bus_if.in_hi    = hi;
        bus_if.in_lo    = lo;
        bus_if.in_wide  = w;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clear_n          = 1'b0;
        bus_if.out_ready = 1'b0;
        drive_in(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        step();
        clear_n = 1'b1;

        // Reset state
        check_eq("rst_count",  32'(count), 32'd0);
        check_eq("rst_ovalid", 32'(bus_if.out_valid), 32'd0);
        check_eq("rst_iready", 32'(bus_if.in_ready), 32'd1);
        check_eq("rst_data",   bus_if.out_data, 32'h0);
        check_eq("rst_last",   32'(bus_if.out_last), 32'd0);
        check_eq("rst_zero",   32'(bus_if.out_zero), 32'd0);

        // 1. Narrow single
        bus_if.out_ready = 1'b1;
        drive_in(1'b1, 32'h0, 32'h4B4B4B4A, 1'b0);
        step();
        drive_in(1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("t1_valid", 32'(bus_if.out_valid), 32'd1);
        check_eq("t1_data",  bus_if.out_data, 32'h4B4B4B4A);
        check_eq("t1_is_hi", 32'(bus_if.out_is_hi), 32'd0);
        check_eq("t1_last",  32'(bus_if.out_last), 32'd1);
        check_eq("t1_zero",  32'(bus_if.out_zero), 32'd0);
        check_eq("t1_count", 32'(count), 32'd1);
        step();
        check_eq("t1_count_after", 32'(count), 32'd0);
        check_eq("t1_valid_after", 32'(bus_if.out_valid), 32'd0);

        // 2. Zero flag; HI of a narrow push is ignored
        drive_in(1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        step();
        drive_in(1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("t2_zero",  32'(bus_if.out_zero), 32'd1);
        check_eq("t2_last",  32'(bus_if.out_last), 32'd1);
        step();
        drive_in(1'b1, 32'h0, 32'h7AB6FBBC, 1'b0);
        step();
        drive_in(1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("t2_data2", bus_if.out_data, 32'h7AB6FBBC);
        check_eq("t2_zero2", 32'(bus_if.out_zero), 32'd0);
        step();

        // 3. Wide entry, nonzero in HI only
        drive_in(1'b1, 32'h00000001, 32'h00000000, 1'b1);
        step();
        drive_in(1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("t3_b1_data",  bus_if.out_data, 32'h00000000);
        check_eq("t3_b1_is_hi", 32'(bus_if.out_is_hi), 32'd0);
        check_eq("t3_b1_last",  32'(bus_if.out_last), 32'd0);
        check_eq("t3_b1_zero",  32'(bus_if.out_zero), 32'd0);
        step();
        check_eq("t3_b2_data",  bus_if.out_data, 32'h00000001);
        check_eq("t3_b2_is_hi", 32'(bus_if.out_is_hi), 32'd1);
        check_eq("t3_b2_last",  32'(bus_if.out_last), 32'd1);
        check_eq("t3_b2_zero",  32'(bus_if.out_zero), 32'd0);
        check_eq("t3_b2_count", 32'(count), 32'd1);
        step();
        check_eq("t3_count_after", 32'(count), 32'd0);

        // 3b. Wide all-zero result flags zero across 64 bits
        drive_in(1'b1, 32'h0, 32'h0, 1'b1);
        step();
        drive_in(1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("t3b_zero", 32'(bus_if.out_zero), 32'd1);
        step();
        step();

        // 4. Backpressure and full
        bus_if.out_ready = 1'b0;
        drive_in(1'b1, 32'h0, 32'h34567800, 1'b0);
        step();
        drive_in(1'b1, 32'h0, 32'h43218765, 1'b0);
        step();
        drive_in(1'b1, 32'h0, 32'hDEADDEAD, 1'b0);
        check_eq("t4_iready_full", 32'(bus_if.in_ready), 32'd0);
        check_eq("t4_count_full",  32'(count), 32'd2);
        check_eq("t4_stall_data",  bus_if.out_data, 32'h34567800);
        step();
        check_eq("t4_count_hold",  32'(count), 32'd2);
        check_eq("t4_stall_data2", bus_if.out_data, 32'h34567800);
        // pop while full with in_valid high: the push must not slip in
        bus_if.out_ready = 1'b1;
        step();
        drive_in(1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("t4_data_2nd", bus_if.out_data, 32'h43218765);
        check_eq("t4_count_1",  32'(count), 32'd1);
        check_eq("t4_iready_back", 32'(bus_if.in_ready), 32'd1);
        step();
        check_eq("t4_count_0",  32'(count), 32'd0);
        check_eq("t4_drained",  32'(bus_if.out_valid), 32'd0);

        // 5. Streaming 1..8
        bus_if.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive_in(1'b1, 32'h0, 32'(i), 1'b0);
            step();
            check_eq($sformatf("t5_data_%0d", i), bus_if.out_data, 32'(i));
            check_eq($sformatf("t5_count_%0d", i), 32'(count), 32'd1);
        end
        drive_in(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        check_eq("t5_count_end", 32'(count), 32'd0);

        // 6. Reset with a wide head half-sent
        bus_if.out_ready = 1'b0;
        drive_in(1'b1, 32'hAAAA0001, 32'hAAAA0000, 1'b1);
        step();
        drive_in(1'b1, 32'h0, 32'h00000011, 1'b0);
        step();
        drive_in(1'b0, 32'h0, 32'h0, 1'b0);
        bus_if.out_ready = 1'b1;
        step();
        bus_if.out_ready = 1'b0;
        check_eq("t6_hi_pending", 32'(bus_if.out_is_hi), 32'd1);
        check_eq("t6_hi_data",    bus_if.out_data, 32'hAAAA0001);
        check_eq("t6_count_full", 32'(count), 32'd2);
        clear_n = 1'b0;
        step();
        clear_n = 1'b1;
        check_eq("t6_count_rst",  32'(count), 32'd0);
        check_eq("t6_ovalid_rst", 32'(bus_if.out_valid), 32'd0);
        check_eq("t6_iready_rst", 32'(bus_if.in_ready), 32'd1);
        bus_if.out_ready = 1'b1;
        drive_in(1'b1, 32'h0, 32'h00000099, 1'b0);
        step();
        drive_in(1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("t6_post_data",  bus_if.out_data, 32'h00000099);
        check_eq("t6_post_is_hi", 32'(bus_if.out_is_hi), 32'd0);
        check_eq("t6_post_last",  32'(bus_if.out_last), 32'd1);
        step();
        check_eq("t6_post_count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
